// File: rtl/rnn_mem_resp.sv
// Memory responder for an RNN engine: weight/bias banks, input vector buffer, result capture and run handshake.
// Optional golden-result checking is built when RNN_MEM_CHECK_EN is defined.
module rnn_mem_resp #(
    parameter int unsigned T_MAX   = 16,
    parameter int unsigned X_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_en,
    input  logic [2:0]  ld_sel,
    input  logic [16:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ready,
    input  logic        busy,
    input  logic        i_en,
    output logic [31:0] idata,
    input  logic        mce,
    input  logic [2:0]  msel,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    output logic [19:0] mdata_r,
    input  logic [16:0] rb_addr,
    output logic [19:0] rb_data,
    output logic        done,
    output logic [16:0] wr_cnt,
    output logic        ovf,
    output logic [15:0] err_cnt
);

    localparam int unsigned DW        = 20;
    localparam int unsigned AW        = 17;
    localparam int unsigned XW        = 32;
    localparam int unsigned WI_DEPTH  = 2048;
    localparam int unsigned WI_AW     = 11;
    localparam int unsigned B_DEPTH   = 64;
    localparam int unsigned B_AW      = 6;
    localparam int unsigned WH_DEPTH  = 4096;
    localparam int unsigned WH_AW     = 12;
    localparam int unsigned RES_DEPTH = T_MAX * 64;
    localparam int unsigned RES_AW    = $clog2(RES_DEPTH);
    localparam int unsigned X_AW      = $clog2(X_DEPTH);
    localparam int unsigned TW        = 11;

    localparam logic [2:0] SEL_WI   = 3'b000;
    localparam logic [2:0] SEL_BI   = 3'b001;
    localparam logic [2:0] SEL_WH   = 3'b010;
    localparam logic [2:0] SEL_BH   = 3'b011;
    localparam logic [2:0] SEL_TLEN = 3'b100;
    localparam logic [2:0] SEL_RES  = 3'b101;
    localparam logic [2:0] SEL_XBUF = 3'b110;
    localparam logic [2:0] SEL_GOLD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] wi     [WI_DEPTH];
    logic [DW-1:0] bi     [B_DEPTH];
    logic [DW-1:0] wh     [WH_DEPTH];
    logic [DW-1:0] bh     [B_DEPTH];
    logic [DW-1:0] result [RES_DEPTH];
    logic [XW-1:0] xbuf   [X_DEPTH];
    logic [DW-1:0] t_len;
`ifdef RNN_MEM_CHECK_EN
    logic [DW-1:0] golden [RES_DEPTH];
`endif

    logic            host_open;
    logic            ld_ok;
    logic            run_clr;
    logic            ready_nxt;
    logic            done_nxt;
    logic [X_AW-1:0] xp;
    logic [X_AW-1:0] xp_nxt;
    logic [X_AW-1:0] x_ld_idx;
    logic            res_wr;
    logic            res_in_rng;
    logic            res_wr_ok;
    logic            rb_in_rng;
    logic [DW-1:0]   rd_val;
    logic [DW-1:0]   rb_val;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_START;
            S_START:        if (busy)  state_nxt = S_RUN;
            S_RUN:          if (!busy) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode; ready and done are registered from the next state
    always_comb begin
        host_open = (state == S_IDLE) || (state == S_DONE);
        ld_ok     = ld_en && host_open;
        run_clr   = start && host_open;
        ready_nxt = (state_nxt == S_START);
        done_nxt  = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= ready_nxt;
            done  <= done_nxt;
        end
    end

    assign x_ld_idx   = X_AW'(ld_addr % AW'(X_DEPTH));
    assign xp_nxt     = (xp == X_AW'(X_DEPTH - 1)) ? '0 : xp + X_AW'(1);
    assign res_wr     = mce && (msel == SEL_RES);
    assign res_in_rng = (maddr[16:6] < TW'(T_MAX));
    assign res_wr_ok  = res_wr && res_in_rng;
    assign rb_in_rng  = (rb_addr < AW'(RES_DEPTH));

    // Bank read mux; unmapped selects and out-of-range addresses read as zero
    always_comb begin
        rd_val = '0;
        case (msel)
            SEL_WI:   if (maddr < AW'(WI_DEPTH)) rd_val = wi[maddr[WI_AW-1:0]];
            SEL_BI:   if (maddr < AW'(B_DEPTH))  rd_val = bi[maddr[B_AW-1:0]];
            SEL_WH:   if (maddr < AW'(WH_DEPTH)) rd_val = wh[maddr[WH_AW-1:0]];
            SEL_BH:   if (maddr < AW'(B_DEPTH))  rd_val = bh[maddr[B_AW-1:0]];
            SEL_TLEN: rd_val = t_len;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        rb_val = '0;
        if (rb_in_rng) rb_val = result[rb_addr[RES_AW-1:0]];
    end

    // Storage has no reset so contents survive a reset mid-run
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            case (ld_sel)
                SEL_WI:   if (ld_addr < AW'(WI_DEPTH)) wi[ld_addr[WI_AW-1:0]] <= ld_data[DW-1:0];
                SEL_BI:   if (ld_addr < AW'(B_DEPTH))  bi[ld_addr[B_AW-1:0]]  <= ld_data[DW-1:0];
                SEL_WH:   if (ld_addr < AW'(WH_DEPTH)) wh[ld_addr[WH_AW-1:0]] <= ld_data[DW-1:0];
                SEL_BH:   if (ld_addr < AW'(B_DEPTH))  bh[ld_addr[B_AW-1:0]]  <= ld_data[DW-1:0];
                SEL_TLEN: t_len <= ld_data[DW-1:0];
                SEL_XBUF: xbuf[x_ld_idx] <= ld_data;
`ifdef RNN_MEM_CHECK_EN
                SEL_GOLD: if (ld_addr < AW'(RES_DEPTH)) golden[ld_addr[RES_AW-1:0]] <= ld_data[DW-1:0];
`endif
                default: ;
            endcase
        end
        if (res_wr_ok) result[maddr[RES_AW-1:0]] <= mdata_w;
    end

    // Registered read data, input pointer and result-write bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdata_r <= '0;
            rb_data <= '0;
            idata   <= '0;
            xp      <= '0;
            wr_cnt  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (mce && (msel != SEL_RES)) mdata_r <= rd_val;
            rb_data <= rb_val;
            if (i_en) idata <= xbuf[xp];
            if (run_clr) begin
                xp     <= '0;
                wr_cnt <= '0;
                ovf    <= 1'b0;
            end else begin
                if (i_en) xp <= xp_nxt;
                if (res_wr) begin
                    if (res_in_rng) wr_cnt <= wr_cnt + AW'(1);
                    else            ovf    <= 1'b1;
                end
            end
        end
    end

`ifdef RNN_MEM_CHECK_EN
    logic gold_miss;

    always_comb begin
        gold_miss = 1'b0;
        if (res_wr_ok) gold_miss = (golden[maddr[RES_AW-1:0]] != mdata_w);
    end

    // Saturating mismatch counter against the golden bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                err_cnt <= '0;
        else if (run_clr)                         err_cnt <= '0;
        else if (gold_miss && (err_cnt != '1))    err_cnt <= err_cnt + 16'(1);
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rnn_mem_resp.sv
// Bench for rnn_mem_resp: directed vector table, hand sequences and random traffic against a reference model.
module tb_rnn_mem_resp;

    localparam int T_MAX     = 16;
    localparam int X_DEPTH   = 16;
    localparam int RES_DEPTH = T_MAX * 64;

    localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_DONE = 3;
    localparam int P_NONE = 0, P_READY = 1, P_DONE = 2, P_MDATA = 3, P_IDATA = 4,
                   P_RB = 5, P_WRCNT = 6, P_OVF = 7, P_ERR = 8;

    logic        clk, reset, start, ld_en, busy, i_en, mce;
    logic [2:0]  ld_sel, msel;
    logic [16:0] ld_addr, maddr, rb_addr;
    logic [31:0] ld_data;
    logic [19:0] mdata_w;
    logic        ready, done, ovf;
    logic [31:0] idata;
    logic [19:0] mdata_r, rb_data;
    logic [16:0] wr_cnt;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    rnn_mem_resp #(.T_MAX(T_MAX), .X_DEPTH(X_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .ready(ready), .busy(busy), .i_en(i_en),
        .idata(idata), .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w),
        .mdata_r(mdata_r), .rb_addr(rb_addr), .rb_data(rb_data), .done(done),
        .wr_cnt(wr_cnt), .ovf(ovf), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: storage as plain arrays, run phase as a number
    logic [19:0] m_wi [2048];
    logic [19:0] m_bi [64];
    logic [19:0] m_wh [4096];
    logic [19:0] m_bh [64];
    logic [19:0] m_res [RES_DEPTH];
    logic [19:0] m_gold [RES_DEPTH];
    logic [31:0] m_xbuf [X_DEPTH];
    logic [19:0] m_tlen;
    int          m_ph, m_xp;
    logic [31:0] m_idata;
    logic [19:0] m_mdata, m_rb;
    logic [16:0] m_wr;
    logic        m_ovf;
    logic [15:0] m_err;

    typedef struct {
        logic        st, bs, le;
        logic [2:0]  ls;
        logic [16:0] la;
        logic [31:0] ld;
        logic        me;
        logic [2:0]  ms;
        logic [16:0] ma;
        logic [19:0] mw;
        logic        ie;
        logic [16:0] ra;
        int          probe;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic bs, input logic le, input logic [2:0] ls,
                                input logic [16:0] la, input logic [31:0] ld, input logic me,
                                input logic [2:0] ms, input logic [16:0] ma, input logic [19:0] mw,
                                input logic ie, input logic [16:0] ra, input int probe, input logic [31:0] exp);
        vec_t v;
        v.st = st; v.bs = bs; v.le = le; v.ls = ls; v.la = la; v.ld = ld;
        v.me = me; v.ms = ms; v.ma = ma; v.mw = mw; v.ie = ie; v.ra = ra;
        v.probe = probe; v.exp = exp;
        return v;
    endfunction

    function automatic string pname(input int p);
        case (p)
            P_READY: return "tbl_ready";
            P_DONE:  return "tbl_done";
            P_MDATA: return "tbl_mdata_r";
            P_IDATA: return "tbl_idata";
            P_RB:    return "tbl_rb_data";
            P_WRCNT: return "tbl_wr_cnt";
            P_OVF:   return "tbl_ovf";
            default: return "tbl_err_cnt";
        endcase
    endfunction

    function automatic logic [31:0] probe_val(input int p);
        case (p)
            P_READY: return 32'(ready);
            P_DONE:  return 32'(done);
            P_MDATA: return 32'(mdata_r);
            P_IDATA: return idata;
            P_RB:    return 32'(rb_data);
            P_WRCNT: return 32'(wr_cnt);
            P_OVF:   return 32'(ovf);
            default: return 32'(err_cnt);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] model_read(input logic [2:0] sel, input logic [16:0] a);
        case (sel)
            3'd0: return (a < 17'd2048) ? m_wi[a] : 20'h0;
            3'd1: return (a < 17'd64)   ? m_bi[a] : 20'h0;
            3'd2: return (a < 17'd4096) ? m_wh[a] : 20'h0;
            3'd3: return (a < 17'd64)   ? m_bh[a] : 20'h0;
            3'd4: return m_tlen;
            default: return 20'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_xp = 0; m_idata = '0; m_mdata = '0; m_rb = '0;
        m_wr = '0; m_ovf = 1'b0; m_err = '0;
    endtask

    // One clock of the model from the current inputs; reads see pre-edge contents
    task automatic model_edge();
        bit open, clr;
        open = (m_ph == PH_IDLE) || (m_ph == PH_DONE);
        clr  = open && start;
        if (mce && msel != 3'd5) m_mdata = model_read(msel, maddr);
        m_rb = (int'(rb_addr) < RES_DEPTH) ? m_res[rb_addr] : 20'h0;
        if (i_en) m_idata = m_xbuf[m_xp];
        if (mce && msel == 3'd5) begin
            if (int'(maddr) / 64 < T_MAX) begin
`ifdef RNN_MEM_CHECK_EN
                if (!clr && m_gold[maddr] != mdata_w && m_err != 16'hFFFF) m_err++;
`endif
                m_res[maddr] = mdata_w;
                if (!clr) m_wr++;
            end else if (!clr) begin
                m_ovf = 1'b1;
            end
        end
        if (clr) begin
            m_xp = 0; m_wr = '0; m_ovf = 1'b0; m_err = '0;
        end else if (i_en) begin
            m_xp = (m_xp + 1) % X_DEPTH;
        end
        if (ld_en && open) begin
            case (ld_sel)
                3'd0: if (ld_addr < 17'd2048) m_wi[ld_addr] = ld_data[19:0];
                3'd1: if (ld_addr < 17'd64)   m_bi[ld_addr] = ld_data[19:0];
                3'd2: if (ld_addr < 17'd4096) m_wh[ld_addr] = ld_data[19:0];
                3'd3: if (ld_addr < 17'd64)   m_bh[ld_addr] = ld_data[19:0];
                3'd4: m_tlen = ld_data[19:0];
                3'd6: m_xbuf[int'(ld_addr) % X_DEPTH] = ld_data;
`ifdef RNN_MEM_CHECK_EN
                3'd7: if (int'(ld_addr) < RES_DEPTH) m_gold[ld_addr] = ld_data[19:0];
`endif
                default: ;
            endcase
        end
        case (m_ph)
            PH_IDLE, PH_DONE: if (start) m_ph = PH_START;
            PH_START:         if (busy)  m_ph = PH_RUN;
            default:          if (!busy) m_ph = PH_DONE;
        endcase
    endtask

    task automatic compare_all();
        check("ready",   32'(ready),   32'(m_ph == PH_START));
        check("done",    32'(done),    32'(m_ph == PH_DONE));
        check("idata",   idata,        m_idata);
        check("mdata_r", 32'(mdata_r), 32'(m_mdata));
        check("rb_data", 32'(rb_data), 32'(m_rb));
        check("wr_cnt",  32'(wr_cnt),  32'(m_wr));
        check("ovf",     32'(ovf),     32'(m_ovf));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic idle_inputs();
        start = 0; ld_en = 0; ld_sel = '0; ld_addr = '0; ld_data = '0; busy = 0;
        i_en = 0; mce = 0; msel = '0; maddr = '0; mdata_w = '0; rb_addr = '0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load(input logic [2:0] sel, input int a, input logic [31:0] d);
        ld_en = 1; ld_sel = sel; ld_addr = 17'(a); ld_data = d;
        cycle();
        ld_en = 0;
    endtask

    function automatic logic [16:0] rnd_addr();
        case ($urandom_range(0, 3))
            0:       return 17'($urandom_range(0, 63));
            1:       return 17'($urandom_range(0, 2047));
            2:       return 17'($urandom_range(0, 4200));
            default: return 17'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < RES_DEPTH; i++) begin m_res[i] = '0; m_gold[i] = '0; end
        m_tlen = '0;
        idle_inputs();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 0;

        // Fill every bank with random data so later reads are fully modelled
        for (int i = 0; i < 2048; i++) load(3'd0, i, $urandom);
        for (int i = 0; i < 64; i++)   load(3'd1, i, $urandom);
        for (int i = 0; i < 4096; i++) load(3'd2, i, $urandom);
        for (int i = 0; i < 64; i++)   load(3'd3, i, $urandom);
        for (int i = 0; i < X_DEPTH; i++) load(3'd6, i, $urandom);
        load(3'd4, 0, $urandom);
        for (int i = 0; i < RES_DEPTH; i++) load(3'd7, i, $urandom);
        for (int i = 0; i < RES_DEPTH; i++) begin
            mce = 1; msel = 3'd5; maddr = 17'(i);
`ifdef RNN_MEM_CHECK_EN
            mdata_w = m_gold[i];
`else
            mdata_w = 20'($urandom);
`endif
            cycle();
        end
        idle_inputs();

        // Directed vectors: st bs le ls la ld me ms ma mw ie ra probe exp
        tbl.push_back(mk(0,0,1,3'd0,17'd5,32'h00123,   0,3'd0,17'd0,20'h0,        0,17'd0,   P_NONE, 0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd0,17'd5,20'h0,        0,17'd0,   P_MDATA,32'h00123));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd6,20'h0,        0,17'd0,   P_MDATA,32'h00123));
        tbl.push_back(mk(0,0,1,3'd4,17'd9,32'h3,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_NONE, 0));
        tbl.push_back(mk(1,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_READY,1));
        tbl.push_back(mk(0,1,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_READY,0));
        tbl.push_back(mk(0,1,0,3'd0,17'd0,32'h0,       1,3'd4,17'd123,20'h0,      0,17'd0,   P_MDATA,3));
        tbl.push_back(mk(0,1,1,3'd0,17'd5,32'hABCDE,   0,3'd0,17'd0,20'h0,        0,17'd0,   P_DONE, 0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_DONE, 1));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd0,17'd5,20'h0,        0,17'd0,   P_MDATA,32'h00123));
        tbl.push_back(mk(0,0,1,3'd6,17'd0,32'hA5A50001,0,3'd0,17'd0,20'h0,        0,17'd0,   P_NONE, 0));
        tbl.push_back(mk(0,0,1,3'd6,17'd17,32'h0000FFFF,0,3'd0,17'd0,20'h0,       0,17'd0,   P_NONE, 0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        1,17'd0,   P_IDATA,32'hA5A50001));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        1,17'd0,   P_IDATA,32'h0000FFFF));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd5,17'd135,20'hF0000,  0,17'd0,   P_WRCNT,1));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd135, P_RB,   32'hF0000));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd5,17'd1024,20'h12345, 0,17'd0,   P_OVF,  1));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_WRCNT,1));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd0,17'd2048,20'h0,     0,17'd0,   P_MDATA,0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd0,17'd5,20'h0,        0,17'd0,   P_MDATA,32'h00123));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd7,17'd5,20'h0,        0,17'd0,   P_MDATA,0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd1024,P_RB,   0));
        tbl.push_back(mk(1,0,1,3'd1,17'd3,32'h00777,   0,3'd0,17'd0,20'h0,        0,17'd0,   P_READY,1));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       1,3'd1,17'd3,20'h0,        0,17'd0,   P_MDATA,32'h00777));
        tbl.push_back(mk(0,1,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_READY,0));
        tbl.push_back(mk(0,0,0,3'd0,17'd0,32'h0,       0,3'd0,17'd0,20'h0,        0,17'd0,   P_DONE, 1));

        foreach (tbl[k]) begin
            start = tbl[k].st; busy = tbl[k].bs; ld_en = tbl[k].le; ld_sel = tbl[k].ls;
            ld_addr = tbl[k].la; ld_data = tbl[k].ld; mce = tbl[k].me; msel = tbl[k].ms;
            maddr = tbl[k].ma; mdata_w = tbl[k].mw; i_en = tbl[k].ie; rb_addr = tbl[k].ra;
            cycle();
            if (tbl[k].probe != P_NONE) check(pname(tbl[k].probe), probe_val(tbl[k].probe), tbl[k].exp);
        end
        idle_inputs();

        // Input pointer wraps after X_DEPTH requests
        start = 1; cycle(); start = 0;
        i_en = 1;
        for (int i = 0; i < X_DEPTH + 1; i++) cycle();
        check("xp_wrap", idata, 32'hA5A50001);
        i_en = 0;
        busy = 1; cycle();
        busy = 0; cycle();
        check("done_after_wrap", 32'(done), 32'd1);

        // Golden compare, then asynchronous reset in the middle of a run
        load(3'd7, 0, 32'h1);
        start = 1; cycle(); start = 0;
        check("ready_armed", 32'(ready), 32'd1);
        busy = 1; mce = 1; msel = 3'd5; maddr = 17'd0; mdata_w = 20'h2;
        cycle();
        mce = 0;
`ifdef RNN_MEM_CHECK_EN
        check("err_cnt_golden", 32'(err_cnt), 32'd1);
`else
        check("err_cnt_tied", 32'(err_cnt), 32'd0);
`endif
        cycle();
        reset = 1;
        #2;
        model_reset();
        compare_all();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        mce = 1; msel = 3'd0; maddr = 17'd5;
        cycle();
        check("wi5_kept", 32'(mdata_r), 32'h00123);
        mce = 0;
        cycle();
        check("idle_after_reset", 32'(done), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            start   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) busy = ~busy;
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_sel  = 3'($urandom);
            ld_addr = rnd_addr();
            ld_data = $urandom;
            mce     = ($urandom_range(0, 1) == 1);
            msel    = 3'($urandom);
            maddr   = rnd_addr();
            mdata_w = 20'($urandom);
            i_en    = ($urandom_range(0, 3) == 0);
            rb_addr = 17'($urandom_range(0, 1100));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
